// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: mem-field bit indices
// and the skid-buffer state encoding.
package pipe_pkg;

  localparam int unsigned MEM_W      = 2;
  localparam int unsigned MEM_WR_BIT = 1;
  localparam int unsigned MEM_RD_BIT = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// Single enable-loaded payload entry; clears to zero on reset.
module pipe_payload_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with stall, flush and a saturating
// back-pressure counter. Define PIPE_STAGE_SKID_EN for a two-entry skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [MEM_W-1:0]  mem_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              ready_o,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [WB_W-1:0]   wb_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [CNT_W-1:0]  bp_cnt_o
);

  // Payload layout, LSB first: rd, wdata, alu, mem, wb
  localparam int unsigned WD_LSB  = RD_W;
  localparam int unsigned ALU_LSB = RD_W + DATA_W;
  localparam int unsigned MEM_LSB = RD_W + 2 * DATA_W;
  localparam int unsigned WB_LSB  = MEM_LSB + MEM_W;
  localparam int unsigned PAY_W   = WB_LSB + WB_W;

  logic             accept;
  logic             pop;
  logic             out_valid;
  logic             main_en;
  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] main_d_pay;
  logic [PAY_W-1:0] main_pay;
  logic [CNT_W-1:0] bp_cnt_q;
  logic [CNT_W-1:0] bp_cnt_d;

  assign pay_in = {wb_i, mem_i, alu_i, wdata_i, rd_i};
  assign accept = valid_i & ready_o & ~stall_i & ~flush_i;
  assign pop    = out_valid & ready_i;

`ifdef PIPE_STAGE_SKID_EN
  skid_state_e      state_q;
  skid_state_e      state_d;
  logic             ready_q;
  logic             skid_en;
  logic             main_from_skid;
  logic [PAY_W-1:0] skid_pay;

  // ready_o is registered: it reflects whether the skid slot is free
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = FULL;
        FULL: begin
          if (accept && !pop) begin
            state_d = SKID;
          end else if (pop && !accept) begin
            state_d = EMPTY;
          end
        end
        SKID:    if (pop) state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Load enables; the skid entry advances to the outputs when the head pops
  always_comb begin
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (!flush_i) begin
      case (state_q)
        EMPTY: main_en = accept;
        FULL: begin
          main_en = accept & pop;
          skid_en = accept & ~pop;
        end
        SKID: begin
          main_en        = pop;
          main_from_skid = 1'b1;
        end
        default: main_en = 1'b0;
      endcase
    end
  end

  pipe_payload_reg #(
    .W(PAY_W)
  ) u_skid (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (skid_en),
    .d_i   (pay_in),
    .q_o   (skid_pay)
  );

  assign main_d_pay = main_from_skid ? skid_pay : pay_in;
  assign out_valid  = (state_q != EMPTY);
  assign ready_o    = ready_q;
`else
  logic valid_q;
  logic valid_d;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign main_en    = accept;
  assign main_d_pay = pay_in;
  assign out_valid  = valid_q;
  assign ready_o    = ~valid_q | ready_i;
`endif

  pipe_payload_reg #(
    .W(PAY_W)
  ) u_main (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (main_en),
    .d_i   (main_d_pay),
    .q_o   (main_pay)
  );

  // Saturating stall-cycle counter; only reset clears it
  always_comb begin
    bp_cnt_d = bp_cnt_q;
    if (out_valid && !ready_i && !(&bp_cnt_q)) begin
      bp_cnt_d = bp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bp_cnt_q <= '0;
    end else begin
      bp_cnt_q <= bp_cnt_d;
    end
  end

  assign valid_o     = out_valid;
  assign wb_o        = out_valid ? main_pay[WB_LSB +: WB_W] : '0;
  assign mem_write_o = out_valid & main_pay[MEM_LSB + MEM_WR_BIT];
  assign mem_read_o  = out_valid & main_pay[MEM_LSB + MEM_RD_BIT];
  assign alu_o       = main_pay[ALU_LSB +: DATA_W];
  assign wdata_o     = main_pay[WD_LSB +: DATA_W];
  assign rd_o        = main_pay[0 +: RD_W];
  assign bp_cnt_o    = bp_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the ALU-result and store-data fields.
REQ-002 Parameter RD_W, default 5, width of the destination-register field.
REQ-003 Parameter WB_W, default 2, width of the write-back control field.
REQ-004 Parameter CNT_W, default 16, width of the back-pressure counter.
REQ-005 Port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst_i, input, 1: reset, asynchronous, active-high.
REQ-007 Upstream inputs: valid_i (1), stall_i (1), flush_i (1), wb_i (WB_W), mem_i (2: [1]=write, [0]=read), alu_i (DATA_W), wdata_i (DATA_W), rd_i (RD_W).
REQ-008 Upstream output: ready_o (1), stage can accept this cycle.
REQ-009 Downstream input: ready_i (1), consumer accepts the current entry.
REQ-010 Downstream outputs: valid_o (1), wb_o (WB_W), mem_write_o (1), mem_read_o (1), alu_o (DATA_W), wdata_o (DATA_W), rd_o (RD_W), bp_cnt_o (CNT_W).

Function
REQ-011 Accept = valid_i & ready_o & !stall_i & !flush_i; an accepted entry captures all payload fields in the same edge.
REQ-012 Pop = valid_o & ready_i; the entry at the outputs is retired on that edge.
REQ-013 Latency: an entry accepted at edge N appears on the outputs after edge N, valid_o=1, with no intermediate cycle.
REQ-014 mem_write_o and mem_read_o are taken from the registered mem field, never directly from mem_i.
REQ-015 While valid_o=0, wb_o, mem_write_o and mem_read_o are 0, giving a bubble. alu_o, wdata_o and rd_o hold their last values.
REQ-016 Without the skid option, ready_o = !valid_o | ready_i (combinational), and simultaneous pop and accept replace the entry in one edge.
REQ-017 stall_i=1 blocks accept only. The held entry stays and may still pop.
REQ-018 flush_i=1 invalidates every held entry on the next edge and drops any same-cycle input. Flush has priority over accept, pop and stall.
REQ-019 bp_cnt_o increments each cycle with valid_o & !ready_i. It saturates at all-ones and does not wrap. It is unaffected by flush and cleared only by reset.
REQ-020 Payload widths pass through unmodified. No sign or zero extension.

Reset
REQ-021 While rst_i=1: valid_o=0, all control outputs 0, alu_o/wdata_o/rd_o=0, bp_cnt_o=0, skid entry empty.
REQ-022 Reset asserted mid-transfer discards all held entries. ready_o after release is 1.

Configuration
REQ-023 Macro PIPE_STAGE_SKID_EN, when defined, adds a second skid entry and makes ready_o a registered signal equal to "skid empty".
REQ-024 With PIPE_STAGE_SKID_EN, the state machine is EMPTY -> FULL on accept.
  - FULL -> SKID on accept & !pop.
  - FULL -> EMPTY on pop & !accept.
  - FULL stays FULL on accept & pop.
  - SKID -> FULL on pop, with the skid entry moving to the outputs.
  - Any state -> EMPTY on flush.
REQ-025 With PIPE_STAGE_SKID_EN, no entry is lost or duplicated when ready_i drops in the same cycle an entry is accepted. Order is FIFO.
REQ-026 Without PIPE_STAGE_SKID_EN, no skid storage exists and REQ-016 applies.

Structure
REQ-027 Shared package pipe_pkg holds the mem-field bit indices (MEM_WR_BIT=1, MEM_RD_BIT=0) and the skid state enum (EMPTY, FULL, SKID).
REQ-028 One sub-module, pipe_payload_reg, holds a single enable-loaded payload entry. It is instantiated once, or twice with skid.

Verification
REQ-029 After reset, send valid_i=1, alu_i=0x0000_0010, rd_i=3, mem_i=2'b10 with ready_i=1. Next cycle: valid_o=1, alu_o=0x10, rd_o=3, mem_write_o=1, mem_read_o=0.
REQ-030 Hold ready_i=0 for 5 cycles with valid_o=1. Required: bp_cnt_o=5 and outputs unchanged. With CNT_W=3, hold 10 cycles: bp_cnt_o=7.
REQ-031 Assert flush_i together with valid_i=1, mem_i=2'b01. Next cycle: valid_o=0, mem_read_o=0, wb_o=0.
REQ-032 Assert stall_i=1 with valid_i=1 and the stage empty. Required: valid_o stays 0. After stall_i drops, the entry appears one cycle later.
REQ-033 With PIPE_STAGE_SKID_EN, stream entries 1,2,3 while ready_i toggles 1,0,0,1,1. Required: outputs 1,2,3 in order, no loss or duplication, and ready_o=0 only while in SKID.
REQ-034 Assert rst_i asynchronously mid-stream between edges. Required: valid_o=0 and bp_cnt_o=0 immediately, without waiting for a clock edge.
